// File: rtl/wavelet_tap_feeder_pkg.sv
// Shared definitions for the wavelet filter-bank front end: default widths
// and the feeder control-state type.
package wavelet_tap_feeder_pkg;

    localparam int unsigned DEF_BITS_PER_ELEM  = 8;
    localparam int unsigned DEF_NUM_ELEM       = 7;
    localparam int unsigned DEF_SUM_TRUNCATION = 8;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        RUN     = 2'd1,
        ISSUE   = 2'd2,
        CAPTURE = 2'd3
    } feeder_state_t;

endpackage

// File: rtl/wavelet_tap_feeder_delay.sv
// Parameterised tap delay line: element 0 (LSBs) is the newest sample,
// the oldest element falls off the top on each shift.
module tap_delay_line #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 7
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   shift_en,
    input  logic [WIDTH-1:0]       din,
    output logic [DEPTH*WIDTH-1:0] taps
);

    always_ff @(posedge clk) begin
        if (clr) begin
            taps <= '0;
        end else if (shift_en) begin
            taps <= {taps[(DEPTH-1)*WIDTH-1:0], din};
        end
    end

endmodule

// File: rtl/wavelet_tap_feeder.sv
// Sample feeder for the fir block: fills the tap delay line, strobes the
// filter every DECIMATE samples once full, and buffers the returned coefficient.
module wavelet_tap_feeder
    import wavelet_tap_feeder_pkg::*;
#(
    parameter int unsigned BITS_PER_ELEM  = DEF_BITS_PER_ELEM,
    parameter int unsigned NUM_ELEM       = DEF_NUM_ELEM,
    parameter int unsigned SUM_TRUNCATION = DEF_SUM_TRUNCATION,
    parameter int unsigned DECIMATE       = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [BITS_PER_ELEM-1:0]          i_sample,
    input  logic                              i_valid,
    output logic                              o_ready,
    output logic [NUM_ELEM*BITS_PER_ELEM-1:0] o_taps,
    output logic                              o_start_calc,
    input  logic [SUM_TRUNCATION-1:0]         i_wavelet,
    output logic [SUM_TRUNCATION-1:0]         o_result,
    output logic                              o_result_valid,
    input  logic                              i_result_ready
);

    localparam int unsigned FW = $clog2(NUM_ELEM + 1);
    localparam int unsigned DW = $clog2(DECIMATE + 1);
    localparam logic [FW-1:0] FILL_LAST = FW'(NUM_ELEM - 1);
    localparam logic [FW-1:0] FILL_FULL = FW'(NUM_ELEM);
    localparam logic [DW-1:0] DEC_LAST  = DW'(DECIMATE - 1);

    feeder_state_t state, state_nxt;
    logic [FW-1:0] fill_cnt;
    logic [DW-1:0] dec_cnt;
    logic          trig_next;
    logic          accept;
    logic          result_blocked;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        o_ready        = 1'b0;
        o_start_calc   = 1'b0;
        trig_next      = 1'b0;
        result_blocked = o_result_valid && !i_result_ready;
        case (state)
            FILL: begin
                o_ready   = 1'b1;
                trig_next = (fill_cnt == FILL_LAST);
            end
            RUN: begin
                // A trigger may only be accepted if the result slot is free by capture time
                trig_next = (dec_cnt == DEC_LAST);
                o_ready   = !(trig_next && result_blocked);
            end
            ISSUE: begin
                o_start_calc = 1'b1;
                state_nxt    = CAPTURE;
            end
            CAPTURE: state_nxt = RUN;
            default: state_nxt = FILL;
        endcase
        if (rst) begin
            o_ready      = 1'b0;
            o_start_calc = 1'b0;
        end
        accept = i_valid && o_ready;
        if (accept && trig_next) begin
            state_nxt = ISSUE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fill_cnt <= '0;
            dec_cnt  <= '0;
        end else if (accept) begin
            if (fill_cnt != FILL_FULL) begin
                fill_cnt <= fill_cnt + FW'(1);
            end
            if (trig_next) begin
                dec_cnt <= '0;
            end else if (state == RUN) begin
                dec_cnt <= dec_cnt + DW'(1);
            end
        end
    end

    // Capture takes priority over a same-edge consume
    always_ff @(posedge clk) begin
        if (rst) begin
            o_result       <= '0;
            o_result_valid <= 1'b0;
        end else if (state == CAPTURE) begin
            o_result       <= i_wavelet;
            o_result_valid <= 1'b1;
        end else if (i_result_ready) begin
            o_result_valid <= 1'b0;
        end
    end

    tap_delay_line #(
        .WIDTH (BITS_PER_ELEM),
        .DEPTH (NUM_ELEM)
    ) u_tap_delay_line (
        .clk      (clk),
        .clr      (rst),
        .shift_en (accept),
        .din      (i_sample),
        .taps     (o_taps)
    );

endmodule

// File: tb/tb_wavelet_tap_feeder.sv
// Randomised bench for wavelet_tap_feeder: two instances (DECIMATE 1 and 4)
// checked every cycle against a sample-count based reference model.
module tb_wavelet_tap_feeder;

    localparam int unsigned BPE   = 8;
    localparam int unsigned NE    = 7;
    localparam int unsigned ST    = 8;
    localparam int unsigned NCYC  = 4000;
    localparam int unsigned HSIZE = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst     [2];
    logic              valid   [2];
    logic [BPE-1:0]    smp     [2];
    logic              rdy     [2];
    logic [NE*BPE-1:0] taps    [2];
    logic              start   [2];
    logic [ST-1:0]     wav     [2];
    logic [ST-1:0]     res     [2];
    logic              res_v   [2];
    logic              res_rdy [2];

    wavelet_tap_feeder #(
        .BITS_PER_ELEM  (BPE),
        .NUM_ELEM       (NE),
        .SUM_TRUNCATION (ST),
        .DECIMATE       (1)
    ) dut_d1 (
        .clk            (clk),
        .rst            (rst[0]),
        .i_sample       (smp[0]),
        .i_valid        (valid[0]),
        .o_ready        (rdy[0]),
        .o_taps         (taps[0]),
        .o_start_calc   (start[0]),
        .i_wavelet      (wav[0]),
        .o_result       (res[0]),
        .o_result_valid (res_v[0]),
        .i_result_ready (res_rdy[0])
    );

    wavelet_tap_feeder #(
        .BITS_PER_ELEM  (BPE),
        .NUM_ELEM       (NE),
        .SUM_TRUNCATION (ST),
        .DECIMATE       (4)
    ) dut_d4 (
        .clk            (clk),
        .rst            (rst[1]),
        .i_sample       (smp[1]),
        .i_valid        (valid[1]),
        .o_ready        (rdy[1]),
        .o_taps         (taps[1]),
        .o_start_calc   (start[1]),
        .i_wavelet      (wav[1]),
        .o_result       (res[1]),
        .o_result_valid (res_v[1]),
        .i_result_ready (res_rdy[1])
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Reference model: accepted-sample history plus cycles left in the calculation
    int unsigned    m_n        [2];
    int unsigned    m_busy     [2];
    logic           m_res_v    [2];
    logic [ST-1:0]  m_res      [2];
    logic [BPE-1:0] m_hist     [2][HSIZE];
    logic           m_hold     [2];

    function automatic int unsigned dec_of(input int k);
        return (k == 0) ? 1 : 4;
    endfunction

    function automatic logic would_trigger(input int k);
        int unsigned m;
        m = m_n[k] + 1;
        return (m == NE) || (m > NE && ((m - NE) % dec_of(k)) == 0);
    endfunction

    function automatic logic [NE*BPE-1:0] model_taps(input int k);
        logic [NE*BPE-1:0] t;
        int unsigned cnt;
        t   = '0;
        cnt = (m_n[k] < NE) ? m_n[k] : NE;
        for (int unsigned i = 0; i < cnt; i++) begin
            t[i*BPE +: BPE] = m_hist[k][m_n[k]-1-i];
        end
        return t;
    endfunction

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; valid[k] = 1'b0; smp[k] = '0; res_rdy[k] = 1'b0; wav[k] = '0;
            m_n[k] = 0; m_busy[k] = 0; m_res_v[k] = 1'b0; m_res[k] = '0; m_hold[k] = 1'b0;
        end
        for (int unsigned cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (cyc < 3) begin
                    rst[k] = 1'b1;
                end else if (m_busy[k] == 2) begin
                    rst[k] = ($urandom_range(0, 5) == 0);
                end else begin
                    rst[k] = ($urandom_range(0, 299) == 0);
                end
                if (!m_hold[k]) begin
                    valid[k] = (cyc < 60) ? 1'b1 : ($urandom_range(0, 3) != 0);
                    smp[k]   = (cyc < 60) ? BPE'(m_n[k] + 1) : BPE'($urandom);
                end
                if (((cyc / 150) % 2) == 0) begin
                    res_rdy[k] = ($urandom_range(0, 7) == 0);
                end else begin
                    res_rdy[k] = ($urandom_range(0, 3) != 0);
                end
                wav[k] = ST'($urandom);
            end
            #1;
            for (int k = 0; k < 2; k++) begin
                logic exp_ready, exp_start, trig, acc;
                trig      = would_trigger(k);
                exp_start = !rst[k] && (m_busy[k] == 2);
                exp_ready = !rst[k] && (m_busy[k] == 0)
                            && !(m_n[k] >= NE && trig && m_res_v[k] && !res_rdy[k]);
                check($sformatf("ready[%0d]", k), 64'(rdy[k]), 64'(exp_ready));
                check($sformatf("start[%0d]", k), 64'(start[k]), 64'(exp_start));
                check($sformatf("taps[%0d]", k), 64'(taps[k]), 64'(model_taps(k)));
                check($sformatf("result_valid[%0d]", k), 64'(res_v[k]), 64'(m_res_v[k]));
                check($sformatf("result[%0d]", k), 64'(res[k]), 64'(m_res[k]));

                acc       = valid[k] && exp_ready;
                m_hold[k] = valid[k] && !acc && !rst[k];
                if (rst[k]) begin
                    m_n[k] = 0; m_busy[k] = 0; m_res_v[k] = 1'b0; m_res[k] = '0;
                end else begin
                    if (m_busy[k] == 1) begin
                        m_res_v[k] = 1'b1;
                        m_res[k]   = wav[k];
                    end else if (m_res_v[k] && res_rdy[k]) begin
                        m_res_v[k] = 1'b0;
                    end
                    if (m_busy[k] > 0) m_busy[k] = m_busy[k] - 1;
                    if (acc) begin
                        if (m_n[k] < HSIZE) m_hist[k][m_n[k]] = smp[k];
                        m_n[k] = m_n[k] + 1;
                        if (trig) m_busy[k] = 2;
                    end
                end
            end
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
